// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC core front end: opcodes, fetch FSM states,
// and the reset program counter.
package cpu_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next program counter select for the fetch stage. Purely combinational;
// the PC register itself lives in fetch_unit.
module fetch_next_pc
   import cpu_pkg::*;
(
   input  logic [31:0]  pc,
   input  logic [31:0]  instr_in,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_pc,
   input  logic         halt_req,
   input  logic         stall,
   input  fetch_state_t state,
   output logic [31:0]  pc_nxt
);

   // Redirect beats halt beats stall beats jump beats sequential; a jump keeps
   // the upper 6 PC bits so it stays inside the current 64M-word region.
   always_comb begin
      pc_nxt = pc;
      unique case (state)
         RUN: begin
            if (redirect_valid)
               pc_nxt = redirect_pc;
            else if (halt_req || stall)
               pc_nxt = pc;
            else if (instr_in[31:26] == OP_J)
               pc_nxt = {pc[31:26], instr_in[25:0]};
            else
               pc_nxt = pc + 32'd1;
         end
         HALT: begin
            if (redirect_valid)
               pc_nxt = redirect_pc;
         end
         default: pc_nxt = pc;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, fetch FSM and the IF/ID register.
//
// state | meaning
// BOOT  | one cycle after reset, PC held, nothing captured
// RUN   | fetching; IF/ID captures unless redirected, halted or stalled
// HALT  | no fetching; redirects still load the PC, resume returns to RUN
module fetch_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc_out,
   input  logic [31:0] instr_in,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   input  logic        resume,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc1,
   output logic        if_id_valid,
   output logic        halted
);

   fetch_state_t state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic         capture;
   logic         flush;

   fetch_next_pc u_next_pc (
      .pc             (pc),
      .instr_in       (instr_in),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .stall          (stall),
      .state          (state),
      .pc_nxt         (pc_nxt)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= BOOT;
      else
         state <= state_nxt;
   end

   // Next state plus IF/ID capture/flush decisions; a redirect in HALT keeps us halted
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      flush     = 1'b0;
      unique case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            if (redirect_valid) begin
               flush = 1'b1;
            end else if (halt_req) begin
               state_nxt = HALT;
               flush     = 1'b1;
            end else if (!stall) begin
               capture = 1'b1;
            end
         end
         HALT: begin
            if (!redirect_valid && resume && !halt_req)
               state_nxt = RUN;
         end
         default: state_nxt = BOOT;
      endcase
   end

   // Program counter register
   always_ff @(posedge clk) begin
      if (reset)
         pc <= RESET_PC;
      else
         pc <= pc_nxt;
   end

   // IF/ID register; a flush only clears valid so the old payload stays visible
   always_ff @(posedge clk) begin
      if (reset) begin
         if_id_instr <= '0;
         if_id_pc1   <= '0;
         if_id_valid <= 1'b0;
      end else if (capture) begin
         if_id_instr <= instr_in;
         if_id_pc1   <= pc + 32'd1;
         if_id_valid <= 1'b1;
      end else if (flush) begin
         if_id_valid <= 1'b0;
      end
   end

   // Registered halt indicator, rising on the edge that enters HALT
   always_ff @(posedge clk) begin
      if (reset)
         halted <= 1'b0;
      else
         halted <= (state_nxt == HALT);
   end

   assign pc_out = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: 256-word memory model indexed by
// pc_out[7:0], expected IF/ID captures queued when stimulus is applied.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_out;
   logic [31:0] instr_in;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        resume;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc1;
   logic        if_id_valid;
   logic        halted;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc1;
   } cap_t;

   logic [31:0] mem [0:255];
   cap_t        sb_q [$];
   cap_t        exp_cap;
   int          n_checks = 0;
   int          n_fail   = 0;

   localparam logic [31:0] WORD_A = 32'hAAAA_0000;
   localparam logic [31:0] WORD_B = 32'hBBBB_0001;
   localparam logic [31:0] WORD_C = 32'hCCCC_0002;
   localparam logic [31:0] WORD_J = 32'h0800_0004;

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .pc_out         (pc_out),
      .instr_in       (instr_in),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .resume         (resume),
      .if_id_instr    (if_id_instr),
      .if_id_pc1      (if_id_pc1),
      .if_id_valid    (if_id_valid),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   assign instr_in = mem[pc_out[7:0]];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, sb_depth=%0d", sb_q.size());
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt_req       = 1'b0;
      resume         = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (2) tick();
      n_checks++;
      if (pc_out !== RESET_PC) begin
         n_fail++;
         $display("FAIL reset_pc: got %h want %h", pc_out, RESET_PC);
      end
      n_checks++;
      if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc1 !== 32'h0 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ifid: valid=%b instr=%h pc1=%h halted=%b want all zero",
                  if_id_valid, if_id_instr, if_id_pc1, halted);
      end
   endtask

   task automatic test_boot_seq();
      reset = 1'b0;
      tick();
      n_checks++;
      if (pc_out !== 32'd0 || if_id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL boot_hold: pc=%h valid=%b want pc=0 valid=0", pc_out, if_id_valid);
      end
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back('{instr: mem[i], pc1: 32'(i + 1)});
         tick();
         n_checks++;
         if (pc_out !== 32'(i + 1)) begin
            n_fail++;
            $display("FAIL boot_seq_pc[%0d]: got %h want %h", i, pc_out, 32'(i + 1));
         end
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL boot_seq_sb[%0d]: got empty scoreboard want entry", i);
         end else begin
            exp_cap = sb_q.pop_front();
            if (if_id_valid !== 1'b1 || if_id_instr !== exp_cap.instr || if_id_pc1 !== exp_cap.pc1) begin
               n_fail++;
               $display("FAIL boot_seq_ifid[%0d]: got v=%b %h/%h want v=1 %h/%h",
                        i, if_id_valid, if_id_instr, if_id_pc1, exp_cap.instr, exp_cap.pc1);
            end
         end
      end
   endtask

   task automatic test_jump();
      redirect_valid = 1'b1;
      redirect_pc    = 32'd9;
      tick();
      idle_inputs();
      n_checks++;
      if (pc_out !== 32'd9 || if_id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL jump_setup: pc=%h valid=%b want pc=9 valid=0", pc_out, if_id_valid);
      end
      sb_q.push_back('{instr: mem[9], pc1: 32'd10});
      sb_q.push_back('{instr: WORD_J, pc1: 32'd11});
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL jump_sb[%0d]: got empty scoreboard want entry", i);
         end else begin
            exp_cap = sb_q.pop_front();
            if (if_id_valid !== 1'b1 || if_id_instr !== exp_cap.instr || if_id_pc1 !== exp_cap.pc1) begin
               n_fail++;
               $display("FAIL jump_ifid[%0d]: got v=%b %h/%h want v=1 %h/%h",
                        i, if_id_valid, if_id_instr, if_id_pc1, exp_cap.instr, exp_cap.pc1);
            end
         end
      end
      n_checks++;
      if (pc_out !== 32'd4) begin
         n_fail++;
         $display("FAIL jump_target: got %h want 00000004", pc_out);
      end
   endtask

   task automatic test_stall();
      sb_q.push_back('{instr: mem[4], pc1: 32'd5});
      tick();
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL stall_pre_sb: got empty scoreboard want entry");
      end else begin
         exp_cap = sb_q.pop_front();
         if (pc_out !== 32'd5 || if_id_valid !== 1'b1 || if_id_instr !== exp_cap.instr || if_id_pc1 !== exp_cap.pc1) begin
            n_fail++;
            $display("FAIL stall_pre: got pc=%h v=%b %h/%h want pc=5 v=1 %h/%h",
                     pc_out, if_id_valid, if_id_instr, if_id_pc1, exp_cap.instr, exp_cap.pc1);
         end
      end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (pc_out !== 32'd5 || if_id_valid !== 1'b1 || if_id_instr !== mem[4] || if_id_pc1 !== 32'd5) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got pc=%h v=%b %h/%h want pc=5 v=1 %h/5",
                     i, pc_out, if_id_valid, if_id_instr, if_id_pc1, mem[4]);
         end
      end
      stall = 1'b0;
      sb_q.push_back('{instr: mem[5], pc1: 32'd6});
      tick();
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL stall_resume_sb: got empty scoreboard want entry");
      end else begin
         exp_cap = sb_q.pop_front();
         if (pc_out !== 32'd6 || if_id_valid !== 1'b1 || if_id_instr !== exp_cap.instr || if_id_pc1 !== exp_cap.pc1) begin
            n_fail++;
            $display("FAIL stall_resume: got pc=%h v=%b %h/%h want pc=6 v=1 %h/%h",
                     pc_out, if_id_valid, if_id_instr, if_id_pc1, exp_cap.instr, exp_cap.pc1);
         end
      end
   endtask

   task automatic test_stall_redirect();
      stall          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'd41;
      tick();
      idle_inputs();
      n_checks++;
      if (pc_out !== 32'd41 || if_id_valid !== 1'b0 || if_id_instr !== mem[5] || if_id_pc1 !== 32'd6) begin
         n_fail++;
         $display("FAIL stall_redirect: got pc=%h v=%b %h/%h want pc=41 v=0 %h/6",
                  pc_out, if_id_valid, if_id_instr, if_id_pc1, mem[5]);
      end
      sb_q.push_back('{instr: mem[41], pc1: 32'd42});
      tick();
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL redirect_fetch_sb: got empty scoreboard want entry");
      end else begin
         exp_cap = sb_q.pop_front();
         if (pc_out !== 32'd42 || if_id_valid !== 1'b1 || if_id_instr !== exp_cap.instr || if_id_pc1 !== exp_cap.pc1) begin
            n_fail++;
            $display("FAIL redirect_fetch: got pc=%h v=%b %h/%h want pc=42 v=1 %h/%h",
                     pc_out, if_id_valid, if_id_instr, if_id_pc1, exp_cap.instr, exp_cap.pc1);
         end
      end
   endtask

   task automatic test_halt();
      redirect_valid = 1'b1;
      redirect_pc    = 32'd7;
      tick();
      idle_inputs();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      n_checks++;
      if (halted !== 1'b1 || pc_out !== 32'd7 || if_id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_enter: got halted=%b pc=%h v=%b want 1/7/0", halted, pc_out, if_id_valid);
      end
      tick();
      n_checks++;
      if (halted !== 1'b1 || pc_out !== 32'd7 || if_id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_idle: got halted=%b pc=%h v=%b want 1/7/0", halted, pc_out, if_id_valid);
      end
      halt_req = 1'b1;
      resume   = 1'b1;
      tick();
      idle_inputs();
      n_checks++;
      if (halted !== 1'b1 || pc_out !== 32'd7) begin
         n_fail++;
         $display("FAIL halt_and_resume: got halted=%b pc=%h want 1/7", halted, pc_out);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'd20;
      tick();
      idle_inputs();
      n_checks++;
      if (halted !== 1'b1 || pc_out !== 32'd20 || if_id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_redirect: got halted=%b pc=%h v=%b want 1/20/0", halted, pc_out, if_id_valid);
      end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      n_checks++;
      if (halted !== 1'b0 || pc_out !== 32'd20 || if_id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_resume: got halted=%b pc=%h v=%b want 0/20/0", halted, pc_out, if_id_valid);
      end
      sb_q.push_back('{instr: mem[20], pc1: 32'd21});
      tick();
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL halt_refetch_sb: got empty scoreboard want entry");
      end else begin
         exp_cap = sb_q.pop_front();
         if (pc_out !== 32'd21 || if_id_valid !== 1'b1 || if_id_instr !== exp_cap.instr || if_id_pc1 !== exp_cap.pc1) begin
            n_fail++;
            $display("FAIL halt_refetch: got pc=%h v=%b %h/%h want pc=21 v=1 %h/%h",
                     pc_out, if_id_valid, if_id_instr, if_id_pc1, exp_cap.instr, exp_cap.pc1);
         end
      end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFF;
      tick();
      idle_inputs();
      n_checks++;
      if (pc_out !== 32'hFFFF_FFFF || pc_out[7:0] !== 8'hFF) begin
         n_fail++;
         $display("FAIL wrap_setup: got pc=%h want ffffffff", pc_out);
      end
      sb_q.push_back('{instr: mem[255], pc1: 32'h0});
      tick();
      n_checks++;
      if (pc_out !== 32'h0 || pc_out[7:0] !== 8'h00) begin
         n_fail++;
         $display("FAIL wrap_pc: got %h want 00000000", pc_out);
      end
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL wrap_sb: got empty scoreboard want entry");
      end else begin
         exp_cap = sb_q.pop_front();
         if (if_id_valid !== 1'b1 || if_id_instr !== exp_cap.instr || if_id_pc1 !== exp_cap.pc1) begin
            n_fail++;
            $display("FAIL wrap_ifid: got v=%b %h/%h want v=1 %h/%h",
                     if_id_valid, if_id_instr, if_id_pc1, exp_cap.instr, exp_cap.pc1);
         end
      end
   endtask

   task automatic test_reset_mid_halt();
      redirect_valid = 1'b1;
      redirect_pc    = 32'd50;
      tick();
      idle_inputs();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      n_checks++;
      if (halted !== 1'b1 || pc_out !== 32'd50) begin
         n_fail++;
         $display("FAIL rst_halt_setup: got halted=%b pc=%h want 1/50", halted, pc_out);
      end
      reset          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'd99;
      resume         = 1'b1;
      stall          = 1'b1;
      tick();
      idle_inputs();
      n_checks++;
      if (pc_out !== RESET_PC || halted !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc1 !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid_halt: got pc=%h halted=%b v=%b %h/%h want all zero",
                  pc_out, halted, if_id_valid, if_id_instr, if_id_pc1);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if (pc_out !== RESET_PC || if_id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_boot_hold: got pc=%h v=%b want 0/0", pc_out, if_id_valid);
      end
      sb_q.push_back('{instr: mem[0], pc1: 32'd1});
      tick();
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL rst_refetch_sb: got empty scoreboard want entry");
      end else begin
         exp_cap = sb_q.pop_front();
         if (pc_out !== 32'd1 || if_id_valid !== 1'b1 || if_id_instr !== exp_cap.instr || if_id_pc1 !== exp_cap.pc1) begin
            n_fail++;
            $display("FAIL rst_refetch: got pc=%h v=%b %h/%h want pc=1 v=1 %h/%h",
                     pc_out, if_id_valid, if_id_instr, if_id_pc1, exp_cap.instr, exp_cap.pc1);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = {OP_ADDI, 18'h0, 8'(i)};
      mem[0]  = WORD_A;
      mem[1]  = WORD_B;
      mem[2]  = WORD_C;
      mem[10] = WORD_J;
      reset   = 1'b1;
      idle_inputs();

      test_reset();
      test_boot_seq();
      test_jump();
      test_stall();
      test_stall_redirect();
      test_halt();
      test_wrap();
      test_reset_mid_halt();

      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d leftover entries want 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 32-bit RISC core, directly upstream of `instr_memory_unit`. It owns the program counter and drives the word address into instruction memory. It registers the returned instruction into the IF/ID pipeline register. It handles stall, flush/redirect from execute, early jump resolution, and halt.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset, as a word address.
- `OP_J`, 6'b000010: opcode of the unconditional jump resolved in fetch.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `pc_out`  out  32: current PC, a word address; drives `Address` of instruction memory. Memory decodes `[7:0]`, so the PC aliases every 256 words.
- `instr_in`  in  32: instruction returned combinationally for `pc_out`.
- `stall`  in  1: hazard stall from decode; holds the PC and IF/ID.
- `redirect_valid`  in  1: taken branch or exception redirect from execute.
- `redirect_pc`  in  32: target word address for `redirect_valid`.
- `halt_req`  in  1: request to stop fetching.
- `resume`  in  1: leave HALT.
- `if_id_instr`  out  32: registered instruction.
- `if_id_pc1`  out  32: registered PC+1 of that instruction.
- `if_id_valid`  out  1: IF/ID holds a real instruction.
- `halted`  out  1: high while the FSM is in HALT.

## Operation
- FSM states:
  - BOOT: entered on reset; lasts exactly 1 cycle; the PC holds and no capture occurs; then goes to RUN.
  - RUN: normal fetching.
  - HALT: no fetching.
- Per-cycle priority in RUN, highest first. Rules 1–6 are evaluated in the order listed.
  1. `reset`
  2. `redirect_valid`
  3. `halt_req`
  4. `stall`
  5. jump predecode
  6. sequential fetch
- Redirect: `pc <= redirect_pc`, `if_id_valid <= 0` (flush). `if_id_instr` and `if_id_pc1` keep their old values. Redirect overrides `stall`.
- Halt (RUN, no redirect): go to HALT. The PC holds. `if_id_valid <= 0`.
- Stall: the PC, `if_id_instr`, `if_id_pc1` and `if_id_valid` all hold.
- Jump predecode: applies when `instr_in[31:26] == OP_J`.
  - `pc <= {pc[31:26], instr_in[25:0]}`.
  - IF/ID captures the jump with `valid = 1`, so decode sees it but takes no further PC action.
- Sequential fetch:
  - `pc <= pc + 1` (mod 2^32).
  - `if_id_instr <= instr_in`, `if_id_pc1 <= pc + 1`, `if_id_valid <= 1`.
- HALT:
  - `redirect_valid` loads the PC and the FSM stays in HALT.
  - `resume` without redirect goes to RUN; fetch resumes the next cycle from the held PC.
  - `halt_req` and `resume` together: stay in HALT.
  - `if_id_valid` stays 0.
- Width rules:
  - PC arithmetic is 32-bit unsigned. 32'hFFFF_FFFF + 1 wraps to 0.
  - Jump targets keep the upper 6 PC bits.

## Timing
- Reset values: `pc_out = RESET_PC`, `if_id_instr = 0`, `if_id_pc1 = 0`, `if_id_valid = 0`, `halted = 0`, state = BOOT.
- `pc_out` is a register output. `instr_in` must settle within the same cycle; the memory read is combinational.
- Fetch latency is 1 cycle: the instruction at `pc_out` in cycle N appears on `if_id_*` after edge N.
- The first valid IF/ID appears 2 edges after reset deasserts: 1 edge leaving BOOT, then the capture.
- A redirect costs 1 bubble; the target is fetched in the cycle after the redirect edge.
- Jump predecode costs 0 bubbles.
- `halted` is registered and rises on the edge that enters HALT.
- `reset` asserted mid-stall, mid-halt or mid-redirect wins unconditionally on that edge.

## Structure
- Shared package `cpu_pkg` holds:
  - `OP_J` and the other opcode constants;
  - the FSM state enum `fetch_state_t` (BOOT, RUN, HALT);
  - the default `RESET_PC`.
- One sub-module, `fetch_next_pc`: combinational next-PC select from the current PC, `instr_in`, the redirect signals, `stall` and the state.
- The top level holds the PC register, the FSM and the IF/ID register.

## Test plan
- Reset, then memory words 0..2 = A, B, C → `pc_out` is 0, 0, 1, 2, 3. IF/ID shows A/1, B/2, C/3 with `valid = 1` from edge 2.
- Word 10 = 32'h0800_0004, sequential fetch from 9 → the PC after fetching 10 is 4. IF/ID holds 32'h0800_0004 with `pc1 = 11`.
- `stall` high for 3 cycles at PC 5 → `pc_out` stays 5 and IF/ID is unchanged. Fetch resumes with PC 6.
- `stall` and `redirect_valid` (target 41) in the same cycle → the next `pc_out` is 41, `if_id_valid = 0`, then word 41 is captured.
- `halt_req` at PC 7 → `halted = 1`, PC held at 7, `valid = 0`. A redirect to 20 while halted gives PC 20, still halted. `resume` → word 20 is fetched next.
- Redirect to 32'hFFFF_FFFF, then a sequential step → `pc_out` wraps to 0. The memory index is `0xFF`, then `0x00`.
